exmem_latch: RTL and testbench
==============================

Name: exmem_latch

Overview:
- Execute-to-memory pipeline stage directly downstream of the ALU.
- Captures the ALU result and flags with the EX control bundle, resolves BEQ/BNE taken-ness from the zero flag, and presents a registered packet to the memory stage.
- Two-entry skid buffer with valid/ready on both sides, so memory-stage back-pressure (cache miss, bus wait) never drops an ALU result.

Parameters:
- WORD_W, 32, datapath width of ALU result and store data
- REG_AW, 5, destination register index width

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- flush  in  1  synchronous squash of all buffered entries (branch mispredict/exception)
- in_valid  in  1  EX packet valid
- in_ready  out  1  stage can accept a packet this cycle
- alu_res  in  WORD_W  ALU result
- flag_z  in  1  ALU zero flag
- flag_n  in  1  ALU negative flag
- flag_v  in  1  ALU overflow/carry flag
- store_data  in  WORD_W  rt value for SW
- dst_reg  in  REG_AW  writeback register index
- reg_wen  in  1  writeback enable
- mem_ren  in  1  load
- mem_wen  in  1  store
- br_beq  in  1  instruction is BEQ
- br_bne  in  1  instruction is BNE
- out_valid  out  1  MEM packet valid
- out_ready  in  1  memory stage consumes packet
- out_res  out  WORD_W  registered alu_res (memory address or writeback value)
- out_store_data  out  WORD_W  registered store_data
- out_dst_reg  out  REG_AW  registered dst_reg
- out_reg_wen, out_mem_ren, out_mem_wen  out  1 each  registered controls
- out_flag_n, out_flag_v  out  1 each  registered flags
- out_br_taken  out  1  (br_beq & flag_z) | (br_bne & ~flag_z), computed at capture

Behaviour:
- Storage: main register M (drives outputs) and skid register S, each with a valid bit.
- Reset (async, nRST low): M and S valid = 0; all out_* data/control = 0; out_valid = 0; in_ready = 1.
- in_ready = ~S.valid, registered-state derived with no combinational path from out_ready.
- Accept when in_valid & in_ready. Pop when out_valid & out_ready.
- Latency: a packet accepted into an empty stage appears on out_* the next cycle.
- M update: when ~M.valid or pop:
  - S.valid: M <= S, S.valid <= 0.
  - else if accept: M <= input.
  - else: M.valid <= 0.
- Accept while M.valid & ~pop (or while S.valid is being drained into M, only when S is already empty): input goes to S, S.valid <= 1.
- Ordering: strictly FIFO. S always holds the younger packet.
- Full: M and S both valid, so in_ready = 0. Input is ignored, not captured.
- Simultaneous pop + accept with S empty: M <= input; out_valid stays 1 (throughput 1/cycle).
- Flush has priority over all other events. Next edge: M.valid = S.valid = 0. Any packet presented that cycle is dropped. Data fields hold stale values and are don't-care while out_valid = 0.
- out_br_taken and flags are held stable with their packet, never recomputed.
- Control outputs out_reg_wen/out_mem_ren/out_mem_wen are forced to 0 when out_valid = 0.
- Reset mid-stall: all entries discarded immediately; in_ready = 1 after release.

Optional Feature:
- EXMEM_OVF_TRAP_EN, when defined:
  - Adds input ovf_trap_en (1, the instruction is signed ADD/SUB) and output out_ovf_exc (1, registered).
  - On capture with flag_v & ovf_trap_en: packet's reg_wen and mem_wen are stored as 0 and out_ovf_exc = 1 for that packet.
  - out_ovf_exc resets to 0 and follows packet ordering through S.
- When not defined: ports absent; flag_v is only passed through.

Test Plan:
- Reset: nRST=0 mid-traffic -> out_valid=0, in_ready=1, out_reg_wen=0 immediately; first packet after release appears 1 cycle after acceptance.
- Streaming: out_ready=1, 8 back-to-back packets alu_res=1..8 -> out_res 1..8 on consecutive cycles, no bubbles.
- Back-pressure: out_ready=0 while sending A=0x10, B=0x20, C=0x30 -> A,B held, in_ready=0 and C not accepted. out_ready=1 -> A then B out, C accepted once in_ready=1.
- Branch: br_beq=1,flag_z=1 -> out_br_taken=1. br_bne=1,flag_z=1 -> 0. br_bne=1,flag_z=0 -> 1. Neither branch -> 0.
- Flush with M and S full plus in_valid=1 -> next cycle out_valid=0, in_ready=1; none of the three packets ever emerge.
- With EXMEM_OVF_TRAP_EN: alu_res=0x80000000, flag_v=1, ovf_trap_en=1, reg_wen=1 -> out_reg_wen=0, out_ovf_exc=1. Same packet with ovf_trap_en=0 -> out_reg_wen=1, out_ovf_exc=0.

Source files
------------

// File: rtl/exmem_latch.sv
// exmem_latch: EX->MEM pipeline register with a two-entry skid buffer and branch resolution.
// Ports: CLK/nRST (async active-low) clock and reset; flush squashes all buffered entries.
//        in_valid/in_ready plus the ALU result, flags, store data and EX controls form the input packet.
//        out_valid/out_ready plus the out_* fields form the registered MEM-stage packet.
//        Build option EXMEM_OVF_TRAP_EN adds ovf_trap_en in and out_ovf_exc out.
module exmem_latch #(
    parameter int WORD_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] alu_res,
    input  logic              flag_z,
    input  logic              flag_n,
    input  logic              flag_v,
    input  logic [WORD_W-1:0] store_data,
    input  logic [REG_AW-1:0] dst_reg,
    input  logic              reg_wen,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic              br_beq,
    input  logic              br_bne,
`ifdef EXMEM_OVF_TRAP_EN
    input  logic              ovf_trap_en,
    output logic              out_ovf_exc,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_res,
    output logic [WORD_W-1:0] out_store_data,
    output logic [REG_AW-1:0] out_dst_reg,
    output logic              out_reg_wen,
    output logic              out_mem_ren,
    output logic              out_mem_wen,
    output logic              out_flag_n,
    output logic              out_flag_v,
    output logic              out_br_taken
);
    typedef struct packed {
        logic [WORD_W-1:0] res;
        logic [WORD_W-1:0] sd;
        logic [REG_AW-1:0] dst;
        logic              rw;
        logic              mr;
        logic              mw;
        logic              n;
        logic              v;
        logic              bt;
`ifdef EXMEM_OVF_TRAP_EN
        logic              ovf;
`endif
    } pkt_t;

    pkt_t in_pkt, m, s;
    logic m_valid, s_valid;
    logic accept, pop;

    // Ready depends only on registered state so out_ready never reaches in_ready combinationally.
    assign in_ready = ~s_valid;
    assign accept   = in_valid & in_ready;
    assign pop      = m_valid & out_ready;

    always_comb begin
        in_pkt     = '0;
        in_pkt.res = alu_res;
        in_pkt.sd  = store_data;
        in_pkt.dst = dst_reg;
        in_pkt.rw  = reg_wen;
        in_pkt.mr  = mem_ren;
        in_pkt.mw  = mem_wen;
        in_pkt.n   = flag_n;
        in_pkt.v   = flag_v;
        in_pkt.bt  = (br_beq & flag_z) | (br_bne & ~flag_z);
`ifdef EXMEM_OVF_TRAP_EN
        // A trapping overflow suppresses the architectural writes of its own packet.
        in_pkt.ovf = flag_v & ovf_trap_en;
        in_pkt.rw  = reg_wen & ~(flag_v & ovf_trap_en);
        in_pkt.mw  = mem_wen & ~(flag_v & ovf_trap_en);
`endif
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m       <= '0;
            s       <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (!m_valid || pop) begin
            // S holds the younger packet, so it always refills M before new input.
            if (s_valid) begin
                m       <= s;
                s_valid <= 1'b0;
            end else if (accept) begin
                m       <= in_pkt;
                m_valid <= 1'b1;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (accept) begin
            s       <= in_pkt;
            s_valid <= 1'b1;
        end
    end

    assign out_valid      = m_valid;
    assign out_res        = m.res;
    assign out_store_data = m.sd;
    assign out_dst_reg    = m.dst;
    assign out_reg_wen    = m.rw & m_valid;
    assign out_mem_ren    = m.mr & m_valid;
    assign out_mem_wen    = m.mw & m_valid;
    assign out_flag_n     = m.n;
    assign out_flag_v     = m.v;
    assign out_br_taken   = m.bt;
`ifdef EXMEM_OVF_TRAP_EN
    assign out_ovf_exc    = m.ovf;
`endif
endmodule

// File: tb/tb_exmem_latch.sv
// tb_exmem_latch: directed scoreboard bench for exmem_latch.
module tb_exmem_latch;
    logic        CLK = 0, nRST = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic        flag_z = 0, flag_n = 0, flag_v = 0, reg_wen = 0, mem_ren = 0, mem_wen = 0;
    logic        br_beq = 0, br_bne = 0, ovf_trap_en = 0;
    logic [31:0] alu_res = 0, store_data = 0;
    logic [4:0]  dst_reg = 0;
    logic        in_ready, out_valid, out_reg_wen, out_mem_ren, out_mem_wen;
    logic        out_flag_n, out_flag_v, out_br_taken, out_ovf_exc;
    logic [31:0] out_res, out_store_data;
    logic [4:0]  out_dst_reg;
    int          total = 0, bad = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] sd;
        logic [4:0]  dst;
        logic        rw, mr, mw, n, v, bt, ovf;
    } pkt_t;

    pkt_t q[$];

    exmem_latch #(.WORD_W(32), .REG_AW(5)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_res(alu_res), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
        .store_data(store_data), .dst_reg(dst_reg),
        .reg_wen(reg_wen), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .br_beq(br_beq), .br_bne(br_bne),
`ifdef EXMEM_OVF_TRAP_EN
        .ovf_trap_en(ovf_trap_en), .out_ovf_exc(out_ovf_exc),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_store_data(out_store_data), .out_dst_reg(out_dst_reg),
        .out_reg_wen(out_reg_wen), .out_mem_ren(out_mem_ren), .out_mem_wen(out_mem_wen),
        .out_flag_n(out_flag_n), .out_flag_v(out_flag_v), .out_br_taken(out_br_taken)
    );
`ifndef EXMEM_OVF_TRAP_EN
    assign out_ovf_exc = 1'b0;
`endif

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic pkt(input logic v, input logic [31:0] r);
        in_valid = v; alu_res = r; store_data = ~r; dst_reg = r[4:0];
        reg_wen = r[0]; mem_ren = r[1]; mem_wen = r[2]; flag_n = r[3]; flag_v = r[4];
        flag_z = r[5]; br_beq = r[6]; br_bne = r[7]; ovf_trap_en = 0;
    endtask

    // Check outputs against the model, apply one clock edge, then advance the model.
    task automatic tick(input string tag);
        pkt_t e, o;
        bit acc, pp;
        o = '{out_res, out_store_data, out_dst_reg, out_reg_wen, out_mem_ren, out_mem_wen,
              out_flag_n, out_flag_v, out_br_taken, out_ovf_exc};
        chk({tag, ".in_ready"}, in_ready, q.size() < 2);
        chk({tag, ".out_valid"}, out_valid, q.size() > 0);
        if (q.size() > 0) chk({tag, ".pkt"}, o, q[0]);
        else chk({tag, ".idle_ctl"}, {out_reg_wen, out_mem_ren, out_mem_wen}, 3'b000);
        e.res = alu_res; e.sd = store_data; e.dst = dst_reg; e.mr = mem_ren;
        e.n = flag_n; e.v = flag_v;
        e.bt = br_beq ? flag_z : (br_bne ? !flag_z : 1'b0);
        e.ovf = flag_v && ovf_trap_en;
        e.rw = e.ovf ? 1'b0 : reg_wen;
        e.mw = e.ovf ? 1'b0 : mem_wen;
        acc = in_valid && q.size() < 2;
        pp = out_ready && q.size() > 0;
        @(posedge CLK);
        if (flush) q.delete();
        else begin
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        @(negedge CLK);
    endtask

    initial begin
        #1;
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.in_ready", in_ready, 1'b1);
        chk("rst.out_res", out_res, 32'h0);
        chk("rst.out_reg_wen", out_reg_wen, 1'b0);
        @(negedge CLK);
        nRST = 1;
        // streaming, 8 back-to-back packets
        out_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            pkt(1, i);
            tick("stream");
        end
        pkt(0, 0);
        tick("stream_tail");
        tick("stream_empty");
        // back-pressure: A, B fill the stage, C is refused
        out_ready = 0;
        pkt(1, 32'h10); tick("bp_a");
        pkt(1, 32'h20); tick("bp_b");
        pkt(1, 32'h30); tick("bp_c_refused");
        tick("bp_c_refused2");
        chk("bp.full_ready", in_ready, 1'b0);
        out_ready = 1;
        tick("bp_pop_a");
        tick("bp_pop_b_acc_c");
        pkt(0, 0);
        tick("bp_pop_c");
        tick("bp_empty");
        // branch resolution
        pkt(1, 32'h100); br_beq = 1; flag_z = 1; tick("br_beq_z");
        pkt(1, 32'h200); br_bne = 1; flag_z = 1; tick("br_bne_z");
        pkt(1, 32'h300); br_bne = 1; flag_z = 0; tick("br_bne_nz");
        pkt(1, 32'h400); flag_z = 1; tick("br_none");
        pkt(0, 0);
        chk("br.none_taken", out_br_taken, 1'b0);
        tick("br_tail");
        // flush with both entries full and a third packet presented
        out_ready = 0;
        pkt(1, 32'hA1); tick("fl_fill1");
        pkt(1, 32'hA3); tick("fl_fill2");
        pkt(1, 32'hA5); flush = 1; tick("fl_flush");
        flush = 0; pkt(0, 0);
        chk("fl.out_valid", out_valid, 1'b0);
        chk("fl.in_ready", in_ready, 1'b1);
        out_ready = 1;
        tick("fl_empty1");
        tick("fl_empty2");
        // asynchronous reset while stalled
        out_ready = 0;
        pkt(1, 32'h41); tick("rs_fill1");
        pkt(1, 32'h43); tick("rs_fill2");
        pkt(0, 0);
        #2 nRST = 0;
        #1;
        chk("rs.out_valid", out_valid, 1'b0);
        chk("rs.in_ready", in_ready, 1'b1);
        chk("rs.out_reg_wen", out_reg_wen, 1'b0);
        q.delete();
        @(negedge CLK);
        nRST = 1;
        out_ready = 1;
        pkt(1, 32'h55); tick("rs_after_acc");
        pkt(0, 0);
        chk("rs.latency_res", out_res, 32'h55);
        tick("rs_after_out");
        tick("rs_after_empty");
`ifdef EXMEM_OVF_TRAP_EN
        pkt(1, 32'h8000_0000); flag_v = 1; ovf_trap_en = 1; reg_wen = 1; tick("ovf_trap");
        chk("ovf.reg_wen", out_reg_wen, 1'b0);
        chk("ovf.exc", out_ovf_exc, 1'b1);
        pkt(1, 32'h8000_0000); flag_v = 1; ovf_trap_en = 0; reg_wen = 1; tick("ovf_notrap");
        chk("novf.reg_wen", out_reg_wen, 1'b1);
        chk("novf.exc", out_ovf_exc, 1'b0);
        pkt(0, 0);
        tick("ovf_tail");
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
